// File: rtl/dmem_responder.sv
// Data-memory responder: word-organised RAM behind a req/ready handshake
// with programmable access latency, word and byte loads/stores.
module dmem_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic        byte_acc,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err,
  output logic        busy
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] CNT_INIT =
    (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        go_resp;

  logic        c_we, c_byte;
  logic [31:0] c_addr, c_wdata;

  logic        e_we, e_byte;
  logic [31:0] e_addr, e_wdata;

  logic          bad;
  logic [AW-1:0] idx;
  logic [1:0]    lane;
  logic [31:0]   word;
  logic [7:0]    lane_data;
  logic [31:0]   wd;
  logic [3:0]    be;

  logic [31:0] mem [DEPTH_WORDS];

  // With LATENCY==1 the commit edge is the accept edge, so use live inputs.
  assign e_we    = (state == IDLE) ? we       : c_we;
  assign e_byte  = (state == IDLE) ? byte_acc : c_byte;
  assign e_addr  = (state == IDLE) ? addr     : c_addr;
  assign e_wdata = (state == IDLE) ? wdata    : c_wdata;

  assign idx  = e_addr[AW+1:2];
  assign lane = e_addr[1:0];
  assign bad  = (!e_byte && (lane != 2'd0))
             || (e_addr[31:2] >= 30'(DEPTH_WORDS));

  assign word      = mem[idx];
  assign lane_data = word[8*lane +: 8];
  assign be        = e_byte ? (4'b0001 << lane) : 4'b1111;
  assign wd        = e_byte ? {4{e_wdata[7:0]}} : e_wdata;

  assign ready = (state == RESP);
  assign busy  = (state != IDLE);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    go_resp   = 1'b0;
    unique case (state)
      IDLE: begin
        if (req) begin
          if (LATENCY == 1) begin
            state_nxt = RESP;
            go_resp   = 1'b1;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt != 4'd0) begin
          cnt_nxt = cnt - 4'd1;
        end else begin
          state_nxt = RESP;
          go_resp   = 1'b1;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      c_we    <= 1'b0;
      c_byte  <= 1'b0;
      c_addr  <= 32'd0;
      c_wdata <= 32'd0;
      rdata   <= 32'd0;
      err     <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (state == IDLE && req) begin
        c_we    <= we;
        c_byte  <= byte_acc;
        c_addr  <= addr;
        c_wdata <= wdata;
      end
      if (go_resp) begin
        err <= bad;
        if (bad || e_we)
          rdata <= 32'd0;
        else if (e_byte)
          rdata <= {24'd0, lane_data};
        else
          rdata <= word;
      end else begin
        err   <= 1'b0;
        rdata <= 32'd0;
      end
    end
  end

  // RAM is not reset; a low reset at the commit edge suppresses the write.
  always_ff @(posedge clk) begin
    if (go_resp && reset && e_we && !bad) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i])
          mem[idx][8*i +: 8] <= wd[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: LATENCY=2 instance for most scenarios,
// LATENCY=1 instance for back-to-back accesses.
module tb_dmem_responder;

  logic        clk;
  logic        reset;
  logic        req, req1;
  logic        we, byte_acc;
  logic [31:0] addr, wdata;
  logic [31:0] rdata, rdata1;
  logic        ready, ready1;
  logic        err, err1;
  logic        busy, busy1;

  int checks;
  int errors;

  dmem_responder #(.DEPTH_WORDS(64), .LATENCY(2)) u_dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .we       (we),
    .byte_acc (byte_acc),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .ready    (ready),
    .err      (err),
    .busy     (busy)
  );

  dmem_responder #(.DEPTH_WORDS(64), .LATENCY(1)) u_dut1 (
    .clk      (clk),
    .reset    (reset),
    .req      (req1),
    .we       (we),
    .byte_acc (byte_acc),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata1),
    .ready    (ready1),
    .err      (err1),
    .busy     (busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One access on u_dut; reports latency (99 on timeout), data, err,
  // busy cycles and whether rdata/err were nonzero while ready was low.
  task automatic access(input logic w, input logic b,
                        input logic [31:0] a, input logic [31:0] d,
                        output int lat, output logic [31:0] rd,
                        output logic e, output int bcnt,
                        output logic zbad);
    @(posedge clk); #1;
    we = w; byte_acc = b; addr = a; wdata = d; req = 1'b1;
    lat = 99; rd = 32'hx; e = 1'bx; bcnt = 0; zbad = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (busy) bcnt++;
      if (ready) begin
        lat = n; rd = rdata; e = err;
        break;
      end
      if (rdata !== 32'd0 || err !== 1'b0) zbad = 1'b1;
    end
    req = 1'b0;
  endtask

  task automatic test_reset;
    #3;
    checks++;
    if ({ready, err, busy, rdata} !== 35'd0) begin
      errors++;
      $display("FAIL reset_out got r%b e%b b%b d%h exp zeros",
               ready, err, busy, rdata);
    end
    checks++;
    if ({ready1, err1, busy1, rdata1} !== 35'd0) begin
      errors++;
      $display("FAIL reset_out1 got r%b e%b b%b d%h exp zeros",
               ready1, err1, busy1, rdata1);
    end
    @(negedge clk); reset = 1'b1;
  endtask

  task automatic test_word;
    int lat, bc; logic [31:0] rd; logic e, zb;
    access(1'b1, 1'b0, 32'h10, 32'hDEADBEEF, lat, rd, e, bc, zb);
    checks++;
    if (lat !== 2 || e !== 1'b0 || rd !== 32'd0 || bc !== 2 || zb) begin
      errors++;
      $display("FAIL str_word got lat%0d e%b d%h busy%0d z%b exp 2 0 0 2 0",
               lat, e, rd, bc, zb);
    end
    access(1'b0, 1'b0, 32'h10, 32'h0, lat, rd, e, bc, zb);
    checks++;
    if (lat !== 2 || e !== 1'b0 || rd !== 32'hDEADBEEF || bc !== 2) begin
      errors++;
      $display("FAIL ldr_word got lat%0d e%b d%h busy%0d exp 2 0 deadbeef 2",
               lat, e, rd, bc);
    end
    checks++;
    if (zb) begin
      errors++;
      $display("FAIL ldr_idle_zero got z%b exp 0", zb);
    end
  endtask

  task automatic test_byte;
    int lat, bc; logic [31:0] rd; logic e, zb;
    access(1'b1, 1'b1, 32'h11, 32'h000000AA, lat, rd, e, bc, zb);
    checks++;
    if (lat !== 2 || e !== 1'b0 || rd !== 32'd0) begin
      errors++;
      $display("FAIL strb got lat%0d e%b d%h exp 2 0 0", lat, e, rd);
    end
    access(1'b0, 1'b0, 32'h10, 32'h0, lat, rd, e, bc, zb);
    checks++;
    if (rd !== 32'hDEADAAEF || e !== 1'b0) begin
      errors++;
      $display("FAIL ldr_after_strb got %h e%b exp deadaaef 0", rd, e);
    end
    access(1'b0, 1'b1, 32'h13, 32'h0, lat, rd, e, bc, zb);
    checks++;
    if (rd !== 32'h000000DE || e !== 1'b0 || lat !== 2) begin
      errors++;
      $display("FAIL ldrb_13 got %h e%b lat%0d exp 000000de 0 2", rd, e, lat);
    end
    access(1'b0, 1'b1, 32'h10, 32'h0, lat, rd, e, bc, zb);
    checks++;
    if (rd !== 32'h000000EF) begin
      errors++;
      $display("FAIL ldrb_10 got %h exp 000000ef", rd);
    end
  endtask

  task automatic test_error;
    int lat, bc; logic [31:0] rd; logic e, zb;
    access(1'b0, 1'b0, 32'h12, 32'h0, lat, rd, e, bc, zb);
    checks++;
    if (lat !== 2 || e !== 1'b1 || rd !== 32'd0) begin
      errors++;
      $display("FAIL ldr_misaligned got lat%0d e%b d%h exp 2 1 0", lat, e, rd);
    end
    access(1'b1, 1'b0, 32'h0, 32'h12345678, lat, rd, e, bc, zb);
    access(1'b1, 1'b0, 32'h100, 32'hFFFFFFFF, lat, rd, e, bc, zb);
    checks++;
    if (lat !== 2 || e !== 1'b1 || rd !== 32'd0) begin
      errors++;
      $display("FAIL str_range got lat%0d e%b d%h exp 2 1 0", lat, e, rd);
    end
    access(1'b1, 1'b1, 32'h101, 32'h000000FF, lat, rd, e, bc, zb);
    checks++;
    if (e !== 1'b1) begin
      errors++;
      $display("FAIL strb_range got e%b exp 1", e);
    end
    access(1'b0, 1'b0, 32'h0, 32'h0, lat, rd, e, bc, zb);
    checks++;
    if (rd !== 32'h12345678 || e !== 1'b0) begin
      errors++;
      $display("FAIL ram_unchanged got %h e%b exp 12345678 0", rd, e);
    end
    access(1'b1, 1'b0, 32'hFC, 32'hA5A5C3C3, lat, rd, e, bc, zb);
    access(1'b0, 1'b0, 32'hFC, 32'h0, lat, rd, e, bc, zb);
    checks++;
    if (rd !== 32'hA5A5C3C3 || e !== 1'b0) begin
      errors++;
      $display("FAIL last_word got %h e%b exp a5a5c3c3 0", rd, e);
    end
  endtask

  task automatic test_back_to_back;
    int lat, bc; logic [31:0] rd; logic e, zb;
    logic [31:0] exp_d [3];
    int k;
    exp_d[0] = 32'h01020304;
    exp_d[1] = 32'h05060708;
    exp_d[2] = 32'h090A0B0C;
    access(1'b1, 1'b0, 32'h20, exp_d[0], lat, rd, e, bc, zb);
    access(1'b1, 1'b0, 32'h24, exp_d[1], lat, rd, e, bc, zb);
    access(1'b1, 1'b0, 32'h28, exp_d[2], lat, rd, e, bc, zb);
    access(1'b1, 1'b0, 32'h2C, 32'h5555AAAA, lat, rd, e, bc, zb);
    @(posedge clk); #1;
    we = 1'b0; byte_acc = 1'b0; addr = 32'h20; req = 1'b1;
    k = 0;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      checks++;
      if (ready !== (c == 2 || c == 5 || c == 8)) begin
        errors++;
        $display("FAIL b2b_ready cycle %0d got %b", c, ready);
      end
      if (ready && k < 3) begin
        checks++;
        if (rdata !== exp_d[k] || err !== 1'b0) begin
          errors++;
          $display("FAIL b2b_data %0d got %h e%b exp %h 0",
                   k, rdata, err, exp_d[k]);
        end
        k++;
      end
      if (c == 1 || c == 4 || c == 7) addr = 32'h2C;
      if (c == 2) addr = 32'h24;
      if (c == 5) addr = 32'h28;
      if (c == 8) req = 1'b0;
    end
  endtask

  task automatic test_reset_abort;
    int lat, bc; logic [31:0] rd; logic e, zb;
    logic seen;
    access(1'b1, 1'b0, 32'h30, 32'h11111111, lat, rd, e, bc, zb);
    @(posedge clk); #1;
    we = 1'b1; byte_acc = 1'b0; addr = 32'h30; wdata = 32'h22222222;
    req = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_wait_busy got %b exp 1", busy);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({ready, err, busy, rdata} !== 35'd0) begin
      errors++;
      $display("FAIL abort_outputs got r%b e%b b%b d%h exp zeros",
               ready, err, busy, rdata);
    end
    req = 1'b0;
    @(negedge clk); reset = 1'b1;
    seen = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (ready || busy) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL abort_no_ready got %b exp 0", seen);
    end
    access(1'b0, 1'b0, 32'h30, 32'h0, lat, rd, e, bc, zb);
    checks++;
    if (rd !== 32'h11111111 || lat !== 2) begin
      errors++;
      $display("FAIL abort_ram got %h lat%0d exp 11111111 2", rd, lat);
    end
  endtask

  task automatic test_latency1;
    @(posedge clk); #1;
    we = 1'b1; byte_acc = 1'b0; addr = 32'h40; wdata = 32'hCAFEF00D;
    req1 = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk); #1;
      checks++;
      if (ready1 !== (c != 2) || busy1 !== (c != 2)) begin
        errors++;
        $display("FAIL lat1_ready cycle %0d got r%b b%b", c, ready1, busy1);
      end
      if (c == 1) begin
        checks++;
        if (rdata1 !== 32'd0 || err1 !== 1'b0) begin
          errors++;
          $display("FAIL lat1_str got %h e%b exp 0 0", rdata1, err1);
        end
        we = 1'b0;
      end
      if (c == 3) begin
        checks++;
        if (rdata1 !== 32'hCAFEF00D || err1 !== 1'b0) begin
          errors++;
          $display("FAIL lat1_ldr got %h e%b exp cafef00d 0", rdata1, err1);
        end
        req1 = 1'b0;
      end
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    reset = 1'b0; req = 1'b0; req1 = 1'b0;
    we = 1'b0; byte_acc = 1'b0; addr = 32'd0; wdata = 32'd0;
    test_reset;
    test_word;
    test_byte;
    test_error;
    test_back_to_back;
    test_reset_abort;
    test_latency1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
